// File: rtl/irq_pending_latch.sv
// Interrupt request front end: synchronises eight request lines, latches edge-mode
// requests until acknowledged, and presents the masked pending vector to the priority encoder.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic       mask_wr,
    input  logic [7:0] mask_wdata,
    input  logic       mode_wr,
    input  logic [7:0] mode_wdata,
    input  logic       ack_valid,
    input  logic [2:0] ack_id,
    output logic [7:0] pend_out,
    output logic       irq_valid,
    output logic [7:0] mask_q,
    output logic [7:0] mode_q,
    output logic [7:0] overflow
);

    logic [SYNC_STAGES-1:0][7:0] sync_r;
    logic [7:0]                  s_d_r;
    logic [7:0]                  pending_r;
    logic [7:0]                  overflow_r;

    logic [7:0] sync_s;
    logic [7:0] rise_s;
    logic [7:0] ack_vec_s;
    logic [7:0] mode_chg_s;
    logic [7:0] pending_nxt_s;
    logic [7:0] overflow_nxt_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain plus one delayed copy of its output for rise detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{8'h00}};
            s_d_r  <= 8'h00;
        end else begin
            sync_r[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
            s_d_r <= sync_s;
        end
    end

    // Per-line event vectors: synced rising edge, decoded ack and mode-change strobe
    always_comb begin
        rise_s = sync_s & ~s_d_r;
        if (ack_valid) begin
            ack_vec_s = 8'h01 << ack_id;
        end else begin
            ack_vec_s = 8'h00;
        end
        if (mode_wr) begin
            mode_chg_s = mode_q ^ mode_wdata;
        end else begin
            mode_chg_s = 8'h00;
        end
    end

    // Next-state for pending and overflow; a mode change dominates rise and ack
    always_comb begin
        pending_nxt_s  = pending_r;
        overflow_nxt_s = overflow_r;
        for (int i = 0; i < 8; i++) begin
            if (mode_chg_s[i]) begin
                pending_nxt_s[i]  = 1'b0;
                overflow_nxt_s[i] = 1'b0;
            end else if (mode_q[i]) begin
                // Edge mode: a new rise beats a same-cycle ack
                if (rise_s[i]) begin
                    pending_nxt_s[i] = 1'b1;
                end else if (ack_vec_s[i]) begin
                    pending_nxt_s[i] = 1'b0;
                end else begin
                    pending_nxt_s[i] = pending_r[i];
                end
                if (rise_s[i] && pending_r[i] && !ack_vec_s[i]) begin
                    overflow_nxt_s[i] = 1'b1;
                end else if (ack_vec_s[i]) begin
                    overflow_nxt_s[i] = 1'b0;
                end else begin
                    overflow_nxt_s[i] = overflow_r[i];
                end
            end else begin
                pending_nxt_s[i]  = sync_s[i];
                overflow_nxt_s[i] = overflow_r[i];
            end
        end
    end

    // Pending and overflow state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= 8'h00;
            overflow_r <= 8'h00;
        end else begin
            pending_r  <= pending_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    // Software-visible mask and mode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= 8'h00;
            mode_q <= 8'h00;
        end else begin
            if (mask_wr) begin
                mask_q <= mask_wdata;
            end
            if (mode_wr) begin
                mode_q <= mode_wdata;
            end
        end
    end

    assign pend_out  = pending_r & mask_q;
    assign irq_valid = |pend_out;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Table-driven bench for irq_pending_latch with a scoreboard queue of expected register state.
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic       mask_wr;
    logic [7:0] mask_wdata;
    logic       mode_wr;
    logic [7:0] mode_wdata;
    logic       ack_valid;
    logic [2:0] ack_id;
    logic [7:0] pend_out;
    logic       irq_valid;
    logic [7:0] mask_q;
    logic [7:0] mode_q;
    logic [7:0] overflow;

    always #5 clk = ~clk;

    irq_pending_latch #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .mode_wr    (mode_wr),
        .mode_wdata (mode_wdata),
        .ack_valid  (ack_valid),
        .ack_id     (ack_id),
        .pend_out   (pend_out),
        .irq_valid  (irq_valid),
        .mask_q     (mask_q),
        .mode_q     (mode_q),
        .overflow   (overflow)
    );

    typedef struct {
        logic [7:0] irq;
        logic       mwr;
        logic [7:0] mwd;
        logic       dwr;
        logic [7:0] dwd;
        logic       av;
        logic [2:0] aid;
        logic [7:0] ep;
        logic [7:0] eo;
        logic [7:0] em;
        logic [7:0] ed;
    } vec_t;

    typedef struct {
        logic [7:0] pend;
        logic [7:0] ovf;
        logic [7:0] mask;
        logic [7:0] mode;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[43];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [7:0] irq, input logic mwr, input logic [7:0] mwd,
                                input logic dwr, input logic [7:0] dwd, input logic av,
                                input logic [2:0] aid, input logic [7:0] ep, input logic [7:0] eo,
                                input logic [7:0] em, input logic [7:0] ed);
        vec_t v;
        v.irq = irq; v.mwr = mwr; v.mwd = mwd; v.dwr = dwr; v.dwd = dwd;
        v.av = av; v.aid = aid; v.ep = ep; v.eo = eo; v.em = em; v.ed = ed;
        return v;
    endfunction

    task automatic check8(input string name, input int idx, input logic [7:0] act,
                          input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        irq_in     = v.irq;
        mask_wr    = v.mwr;
        mask_wdata = v.mwd;
        mode_wr    = v.dwr;
        mode_wdata = v.dwd;
        ack_valid  = v.av;
        ack_id     = v.aid;
        e.pend = v.ep; e.ovf = v.eo; e.mask = v.em; e.mode = v.ed;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check8("pend_out",  idx, pend_out, e.pend);
        check8("irq_valid", idx, {7'h00, irq_valid}, {7'h00, |e.pend});
        check8("overflow",  idx, overflow, e.ovf);
        check8("mask_q",    idx, mask_q,   e.mask);
        check8("mode_q",    idx, mode_q,   e.mode);
    endtask

    initial begin
        //            irq    mwr  mwd    dwr  dwd    av   aid   pend   ovf    mask   mode
        // edge latch + ack on line 5
        tbl[0]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'hFF);
        tbl[1]  = mk(8'h20, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'hFF);
        tbl[2]  = mk(8'h20, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'hFF);
        tbl[3]  = mk(8'h20, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h20, 8'h00, 8'hFF, 8'hFF);
        tbl[4]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h20, 8'h00, 8'hFF, 8'hFF);
        tbl[5]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h20, 8'h00, 8'hFF, 8'hFF);
        tbl[6]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd5, 8'h00, 8'h00, 8'hFF, 8'hFF);
        // masked capture on line 3, exposed by unmasking
        tbl[7]  = mk(8'h08, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'hFF);
        tbl[8]  = mk(8'h08, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'hFF);
        tbl[9]  = mk(8'h08, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'hFF);
        tbl[10] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'hFF);
        tbl[11] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'hFF);
        tbl[12] = mk(8'h00, 1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 8'h08, 8'h00, 8'h08, 8'hFF);
        tbl[13] = mk(8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 8'h00, 8'h00, 8'hFF, 8'hFF);
        // set-beats-clear and overflow on line 2
        tbl[14] = mk(8'h04, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'hFF);
        tbl[15] = mk(8'h04, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'hFF);
        tbl[16] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00, 8'hFF, 8'hFF);
        tbl[17] = mk(8'h04, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00, 8'hFF, 8'hFF);
        tbl[18] = mk(8'h04, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00, 8'hFF, 8'hFF);
        tbl[19] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 8'h04, 8'h00, 8'hFF, 8'hFF);
        tbl[20] = mk(8'h04, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00, 8'hFF, 8'hFF);
        tbl[21] = mk(8'h04, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00, 8'hFF, 8'hFF);
        tbl[22] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h04, 8'h04, 8'hFF, 8'hFF);
        tbl[23] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 8'h00, 8'h00, 8'hFF, 8'hFF);
        tbl[24] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd6, 8'h00, 8'h00, 8'hFF, 8'hFF);
        // level mode follows the synced input; ack ignored
        tbl[25] = mk(8'h81, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h00);
        tbl[26] = mk(8'h81, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h00);
        tbl[27] = mk(8'h81, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h81, 8'h00, 8'hFF, 8'h00);
        tbl[28] = mk(8'h81, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd7, 8'h81, 8'h00, 8'hFF, 8'h00);
        tbl[29] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h81, 8'h00, 8'hFF, 8'h00);
        tbl[30] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h81, 8'h00, 8'hFF, 8'h00);
        tbl[31] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h00);
        // mode change clears pending and overflow on line 4
        tbl[32] = mk(8'h10, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h10);
        tbl[33] = mk(8'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h10);
        tbl[34] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h10, 8'h00, 8'hFF, 8'h10);
        tbl[35] = mk(8'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h10, 8'h00, 8'hFF, 8'h10);
        tbl[36] = mk(8'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h10, 8'h00, 8'hFF, 8'h10);
        tbl[37] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h10, 8'h10, 8'hFF, 8'h10);
        tbl[38] = mk(8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h00);
        tbl[39] = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h00);
        // level request on line 0, used to check mid-operation reset afterwards
        tbl[40] = mk(8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h00);
        tbl[41] = mk(8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h00);
        tbl[42] = mk(8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h01, 8'h00, 8'hFF, 8'h00);

        // Reset held with requests and a mask write active
        rst_n      = 1'b0;
        irq_in     = 8'hFF;
        mask_wr    = 1'b1;
        mask_wdata = 8'hFF;
        mode_wr    = 1'b0;
        mode_wdata = 8'h00;
        ack_valid  = 1'b0;
        ack_id     = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check8("rst pend_out",  -1, pend_out, 8'h00);
        check8("rst irq_valid", -1, {7'h00, irq_valid}, 8'h00);
        check8("rst overflow",  -1, overflow, 8'h00);
        check8("rst mask_q",    -1, mask_q, 8'h00);
        check8("rst mode_q",    -1, mode_q, 8'h00);

        // Release mid-cycle; the pending mask write must wait for the next edge
        @(negedge clk);
        irq_in = 8'h00;
        rst_n  = 1'b1;
        #1;
        check8("release mask_q", -1, mask_q, 8'h00);
        check8("release pend_out", -1, pend_out, 8'h00);
        #3;
        check8("pre-edge mask_q", -1, mask_q, 8'h00);
        @(posedge clk);
        #1;
        check8("first-edge mask_q", -1, mask_q, 8'hFF);
        mask_wr = 1'b0;

        for (int i = 0; i < 43; i++) begin
            apply(tbl[i], i);
        end

        // Asynchronous reset in the middle of a cycle with a request pending
        #2;
        rst_n = 1'b0;
        #1;
        check8("async rst pend_out",  -2, pend_out, 8'h00);
        check8("async rst irq_valid", -2, {7'h00, irq_valid}, 8'h00);
        check8("async rst overflow",  -2, overflow, 8'h00);
        check8("async rst mask_q",    -2, mask_q, 8'h00);
        check8("async rst mode_q",    -2, mode_q, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
